// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared types and helpers for the VGA pixel fetcher.
package vga_fetch_pkg;

  // One RGB332 pixel as stored in the framebuffer.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Fetcher control states.
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FETCH      = 2'd1,
    DONE       = 2'd2
  } fetch_state_t;

  // Number of visible pixels in one frame (FRAME_PIXELS).
  function automatic int unsigned frame_pixels(input int unsigned h_active,
                                               input int unsigned v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous show-ahead FIFO of RGB332 pixels.
// The head entry is visible on `head` without a pop; `head` reads 0 when empty.
// Flush has priority over push and pop.
module pixel_fifo
  import vga_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  rgb332_t        din,
  output rgb332_t        head,
  output logic [PTR_W:0] count,
  output logic           empty,
  output logic           full
);

  rgb332_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? rgb332_t'('0) : mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and count define validity,
  // so resetting the array would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_fetcher.sv
// vga_pixel_fetcher: streams one frame of RGB332 pixels from a framebuffer
// into a show-ahead FIFO feeding the VGA driver. Restarts on every vsync rise.
// Optional build macro VGA_FETCH_STATS_EN adds the 16-bit underflow_cnt port.
module vga_pixel_fetcher
  import vga_fetch_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk25MHz,
  input  logic              rst,
  input  logic              en,
  input  logic              need_pixel,
  input  logic              vsync,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        colors,
  output logic              underflow,
  output logic [CNT_W-1:0]  fill_level
`ifdef VGA_FETCH_STATS_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int unsigned       PIXELS    = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  fetch_state_t     state_q, state_d;
  logic             vsync_q;
  logic             frame_start;
  logic             accept;
  logic             pop_req;
  logic             underflow_hit;
  logic             mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             underflow_d;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W:0]   credit_sum;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  rgb332_t          fifo_head;

  assign frame_start   = vsync & ~vsync_q;
  assign accept        = mem_req & mem_ready;
  assign pop_req       = need_pixel & en;
  assign underflow_hit = pop_req & fifo_empty;
  // Responses to requests issued before the last frame start are dropped.
  assign fifo_push     = mem_rvalid & (discard_q == '0) & ~fifo_full;
  assign fifo_pop      = pop_req & ~fifo_empty;

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk25MHz),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (frame_start),
    .din   (rgb332_t'(mem_rdata)),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign colors     = fifo_head;
  assign fill_level = fifo_count;

  // Predict next-cycle FIFO occupancy so credit is judged on the values
  // that hold when a newly raised request becomes visible.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = fifo_count;
    if (frame_start)               count_next = '0;
    else if (fifo_push && !fifo_pop) count_next = fifo_count + 1'b1;
    else if (!fifo_push && fifo_pop) count_next = fifo_count - 1'b1;
  end

  // Next-state, request handshake, credit and bookkeeping.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    out_d       = out_q;
    discard_d   = discard_q;
    underflow_d = underflow | underflow_hit;
    credit_sum  = '0;

    unique case ({accept, mem_rvalid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (mem_rvalid && discard_q != '0) discard_d = discard_q - 1'b1;

    unique case (state_q)
      FETCH:      if (accept && mem_addr == LAST_ADDR) state_d = DONE;
      WAIT_FRAME: state_d = WAIT_FRAME;
      DONE:       state_d = DONE;
      default:    state_d = WAIT_FRAME;
    endcase

    // The address stops on the last pixel rather than wrapping.
    if (accept && mem_addr != LAST_ADDR) mem_addr_d = mem_addr + 1'b1;

    // A pending request holds until accepted; otherwise raise on credit.
    credit_sum = {1'b0, count_next} + {1'b0, out_d};
    if (mem_req && !accept) mem_req_d = 1'b1;
    else mem_req_d = (state_d == FETCH) && (credit_sum < (CNT_W+1)'(FIFO_DEPTH));

    // Frame start abandons any unaccepted request and marks every
    // in-flight read as stale.
    if (frame_start) begin
      state_d     = FETCH;
      mem_req_d   = 1'b0;
      mem_addr_d  = '0;
      discard_d   = out_d;
      underflow_d = 1'b0;
    end
  end

  // Control and handshake registers.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      state_q   <= WAIT_FRAME;
      vsync_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      out_q     <= '0;
      discard_q <= '0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= vsync;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      underflow <= underflow_d;
    end
  end

`ifdef VGA_FETCH_STATS_EN
  logic [15:0] ucnt_q;

  // Per-frame saturating count of pops attempted on an empty FIFO.
  always_ff @(posedge clk25MHz) begin
    if (rst || frame_start)                      ucnt_q <= '0;
    else if (underflow_hit && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 1'b1;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule
